// File: rtl/gem_link_pkg.sv
// Shared GEM trigger-fiber link definitions: control characters, charisk patterns,
// link FSM states and the separator rotation used by both fiber directions.
package gem_link_pkg;

  localparam logic [7:0] K_BC = 8'hBC;
  localparam logic [7:0] K_F7 = 8'hF7;
  localparam logic [7:0] K_FB = 8'hFB;
  localparam logic [7:0] K_FD = 8'hFD;
  localparam logic [7:0] K_FC = 8'hFC;

  localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;

  localparam logic [3:0] ISK_HI   = 4'b0000;
  localparam logic [3:0] ISK_LO   = 4'b0001;
  localparam logic [3:0] ISK_IDLE = 4'b0101;

  // ST_ prefix keeps ST_LOCKED from colliding with the LOCKED port name.
  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_IDLE_RX = 2'd3
  } link_state_t;

  typedef enum logic [2:0] {
    W_NONE = 3'd0,
    W_D    = 3'd1,
    W_K    = 3'd2,
    W_I    = 3'd3,
    W_BAD  = 3'd4
  } word_t;

  // Separator rotation BC->F7->FB->FD->BC; anything else restarts at BC.
  function automatic logic [7:0] next_sep(input logic [7:0] sep);
    case (sep)
      K_BC:    next_sep = K_F7;
      K_F7:    next_sep = K_FB;
      K_FB:    next_sep = K_FD;
      default: next_sep = K_BC;
    endcase
  endfunction

endpackage

// File: rtl/gem_frame_sep_check.sv
// Tracks the expected frame separator, treats FC (overflow) as a wildcard,
// and flags/counts out-of-sequence separators on good frames.
module gem_frame_sep_check
  import gem_link_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             TRG_CLK80,
  input  logic             TRG_RST_N,
  input  logic             chk,
  input  logic             unseed,
  input  logic             clr_cnt,
  input  logic [7:0]       sep,
  output logic             seq_err,
  output logic [ERR_W-1:0] seq_err_cnt
);

  logic [7:0] exp_sep;
  logic       seeded;
  logic       mismatch;

  assign mismatch = chk && seeded && (sep != K_FC) && (sep != exp_sep);

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      exp_sep     <= K_BC;
      seeded      <= 1'b0;
      seq_err     <= 1'b0;
      seq_err_cnt <= '0;
    end else begin
      seq_err <= mismatch;
      if (clr_cnt)
        seq_err_cnt <= '0;
      else if (mismatch && (seq_err_cnt != '1))
        seq_err_cnt <= seq_err_cnt + 1'b1;

      if (unseed) begin
        seeded  <= 1'b0;
        exp_sep <= K_BC;
      end else if (chk) begin
        // An overflow seed says nothing about position, so stay unseeded.
        if (!seeded) begin
          if (sep != K_FC) begin
            seeded  <= 1'b1;
            exp_sep <= next_sep(sep);
          end
        end else if (mismatch) begin
          exp_sep <= next_sep(sep);
        end else begin
          exp_sep <= next_sep(exp_sep);
        end
      end
    end
  end

endmodule

// File: rtl/gem_fiber_in.sv
// GEM trigger fiber receive decoder: aligns to the 2-word frame, rebuilds the
// 56-bit payload, tracks link lock/idle state and counts frame and separator errors.
module gem_fiber_in
  import gem_link_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             TRG_CLK80,
  input  logic             TRG_RST_N,
  input  logic [31:0]      RX_DATA,
  input  logic [3:0]       RX_ISK,
  input  logic             RX_CODE_ERR,
  input  logic             CLR_CNT,
  output logic [55:0]      GEM_DATA,
  output logic             GEM_OVERFLOW,
  output logic             DATA_VALID,
  output logic             LOCKED,
  output logic             LINK_RST,
  output logic             SEQ_ERR,
  output logic [ERR_W-1:0] SEQ_ERR_CNT,
  output logic [ERR_W-1:0] FRM_ERR_CNT,
  output logic [1:0]       DBG_STATE
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_CNT);
  localparam logic [BW-1:0] UNLOCK_V = BW'(UNLOCK_CNT);

  // DATA_VALID is a one-cycle strobe with no ready: the consumer must take
  // GEM_DATA/GEM_OVERFLOW in the cycle DATA_VALID is high.

  logic [31:0] s1_data;
  logic [3:0]  s1_isk;
  logic        s1_err, s1_vld;
  word_t       wtype;
  logic        sep_ok;

  link_state_t   state_q, state_n;
  logic          expect_lo, expect_lo_n;
  logic          hi_ok, hi_ok_n;
  logic          prev_d, prev_d_n;
  logic          prev_i, prev_i_n;
  logic [GW-1:0] good_cnt, good_cnt_n;
  logic [BW-1:0] bad_cnt, bad_cnt_n;
  logic          load_hi, good_frame, bad_frame, go_hunt, unseed;
  logic [31:0]   hi_word;

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      s1_data <= '0;
      s1_isk  <= '0;
      s1_err  <= 1'b0;
      s1_vld  <= 1'b0;
    end else begin
      s1_data <= RX_DATA;
      s1_isk  <= RX_ISK;
      s1_err  <= RX_CODE_ERR;
      s1_vld  <= 1'b1;
    end
  end

  assign sep_ok = (s1_data[7:0] == K_BC) || (s1_data[7:0] == K_F7) || (s1_data[7:0] == K_FB) ||
                  (s1_data[7:0] == K_FD) || (s1_data[7:0] == K_FC);

  always_comb begin
    wtype = W_BAD;
    if (!s1_vld)
      wtype = W_NONE;
    else if (s1_err)
      wtype = W_BAD;
    else if (s1_isk == ISK_HI)
      wtype = W_D;
    else if ((s1_isk == ISK_LO) && sep_ok)
      wtype = W_K;
    else if ((s1_isk == ISK_IDLE) && (s1_data == IDLE_WORD))
      wtype = W_I;
  end

  always_comb begin
    state_n     = state_q;
    expect_lo_n = expect_lo;
    hi_ok_n     = hi_ok;
    prev_d_n    = prev_d;
    prev_i_n    = prev_i;
    good_cnt_n  = good_cnt;
    bad_cnt_n   = bad_cnt;
    load_hi     = 1'b0;
    good_frame  = 1'b0;
    bad_frame   = 1'b0;
    go_hunt     = 1'b0;
    if (wtype != W_NONE) begin
      prev_i_n = (wtype == W_I);
      if ((wtype == W_I) && prev_i) begin
        state_n = ST_IDLE_RX;
      end else begin
        case (state_q)
          ST_HUNT: begin
            prev_d_n = (wtype == W_D);
            load_hi  = (wtype == W_D);
            if ((wtype == W_K) && prev_d) begin
              good_cnt_n  = GW'(1);
              bad_cnt_n   = '0;
              expect_lo_n = 1'b0;
              state_n     = (GW'(1) == LOCK_V) ? ST_LOCKED : ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (!expect_lo) begin
              if (wtype == W_D) begin
                load_hi     = 1'b1;
                expect_lo_n = 1'b1;
              end else begin
                go_hunt = 1'b1;
              end
            end else if (wtype == W_K) begin
              good_frame  = 1'b1;
              expect_lo_n = 1'b0;
              good_cnt_n  = good_cnt + GW'(1);
              if ((good_cnt + GW'(1)) == LOCK_V) begin
                state_n   = ST_LOCKED;
                bad_cnt_n = '0;
              end
            end else begin
              go_hunt = 1'b1;
            end
          end
          ST_LOCKED: begin
            // Phase is trusted once locked: always step hi/lo, judge the pair at the lo word.
            if (!expect_lo) begin
              load_hi     = (wtype == W_D);
              hi_ok_n     = (wtype == W_D);
              expect_lo_n = 1'b1;
            end else begin
              expect_lo_n = 1'b0;
              if (hi_ok && (wtype == W_K)) begin
                good_frame = 1'b1;
                bad_cnt_n  = '0;
              end else begin
                bad_frame = 1'b1;
                bad_cnt_n = bad_cnt + BW'(1);
                if ((bad_cnt + BW'(1)) == UNLOCK_V) go_hunt = 1'b1;
              end
            end
          end
          ST_IDLE_RX: begin
            // Transmitter restarts on a hi word, so the first D fixes the phase.
            if (wtype == W_D) begin
              load_hi     = 1'b1;
              expect_lo_n = 1'b1;
              good_cnt_n  = '0;
              state_n     = ST_SYNC;
            end else if (wtype != W_I) begin
              go_hunt = 1'b1;
            end
          end
          default: go_hunt = 1'b1;
        endcase
      end
      if (go_hunt) begin
        state_n  = ST_HUNT;
        prev_d_n = 1'b0;
      end
    end
  end

  assign unseed = (state_n == ST_HUNT) || (state_n == ST_IDLE_RX);

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      state_q      <= ST_HUNT;
      expect_lo    <= 1'b0;
      hi_ok        <= 1'b0;
      prev_d       <= 1'b0;
      prev_i       <= 1'b0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      hi_word      <= '0;
      GEM_DATA     <= '0;
      GEM_OVERFLOW <= 1'b0;
      DATA_VALID   <= 1'b0;
      FRM_ERR_CNT  <= '0;
    end else begin
      state_q    <= state_n;
      expect_lo  <= expect_lo_n;
      hi_ok      <= hi_ok_n;
      prev_d     <= prev_d_n;
      prev_i     <= prev_i_n;
      good_cnt   <= good_cnt_n;
      bad_cnt    <= bad_cnt_n;
      if (load_hi) hi_word <= s1_data;
      DATA_VALID <= good_frame && (state_q == ST_LOCKED);
      if (good_frame && (state_q == ST_LOCKED)) begin
        GEM_DATA     <= {hi_word, s1_data[31:8]};
        GEM_OVERFLOW <= (s1_data[7:0] == K_FC);
      end
      if (CLR_CNT)
        FRM_ERR_CNT <= '0;
      else if (bad_frame && (FRM_ERR_CNT != '1))
        FRM_ERR_CNT <= FRM_ERR_CNT + 1'b1;
    end
  end

  assign LOCKED    = (state_q == ST_LOCKED);
  assign LINK_RST  = (state_q == ST_IDLE_RX);
  assign DBG_STATE = state_q;

  gem_frame_sep_check #(.ERR_W(ERR_W)) u_sep_check (
    .TRG_CLK80   (TRG_CLK80),
    .TRG_RST_N   (TRG_RST_N),
    .chk         (good_frame),
    .unseed      (unseed),
    .clr_cnt     (CLR_CNT),
    .sep         (s1_data[7:0]),
    .seq_err     (SEQ_ERR),
    .seq_err_cnt (SEQ_ERR_CNT)
  );

endmodule

// File: tb/tb_gem_fiber_in.sv
// Directed bench for gem_fiber_in: frames are driven word by word, expected
// outputs (with their due cycle) are queued and matched when DATA_VALID fires.
module tb_gem_fiber_in;
  import gem_link_pkg::*;

  localparam int ERR_W = 4;
  localparam int W     = 90;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      RX_DATA;
  logic [3:0]       RX_ISK;
  logic             RX_CODE_ERR;
  logic             CLR_CNT;
  logic [55:0]      GEM_DATA;
  logic             GEM_OVERFLOW, DATA_VALID, LOCKED, LINK_RST, SEQ_ERR;
  logic [ERR_W-1:0] SEQ_ERR_CNT, FRM_ERR_CNT;
  logic [1:0]       DBG_STATE;

  gem_fiber_in #(.LOCK_CNT(8), .UNLOCK_CNT(4), .ERR_W(ERR_W)) dut (
    .TRG_CLK80    (clk),
    .TRG_RST_N    (rst_n),
    .RX_DATA      (RX_DATA),
    .RX_ISK       (RX_ISK),
    .RX_CODE_ERR  (RX_CODE_ERR),
    .CLR_CNT      (CLR_CNT),
    .GEM_DATA     (GEM_DATA),
    .GEM_OVERFLOW (GEM_OVERFLOW),
    .DATA_VALID   (DATA_VALID),
    .LOCKED       (LOCKED),
    .LINK_RST     (LINK_RST),
    .SEQ_ERR      (SEQ_ERR),
    .SEQ_ERR_CNT  (SEQ_ERR_CNT),
    .FRM_ERR_CNT  (FRM_ERR_CNT),
    .DBG_STATE    (DBG_STATE)
  );

  // clock / cycle counter
  always #6 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {due cycle, SEQ_ERR, GEM_OVERFLOW, GEM_DATA}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] item;
  int compared   = 0;
  int mismatched = 0;
  int si         = 0;
  logic [7:0] seps [4];
  logic [7:0] seq_seps [12];
  logic [55:0] d;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (DATA_VALID) begin
        chk("valid_has_expectation", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          item = exp_q.pop_front();
          chk("frame_out", {cyc, SEQ_ERR, GEM_OVERFLOW, GEM_DATA}, item);
        end
      end else begin
        chk("seq_err_without_valid", SEQ_ERR, 1'b0);
      end
    end
  end

  // drivers
  function automatic logic [55:0] rnd56();
    return {24'($urandom), $urandom};
  endfunction

  task automatic send_word(input logic [31:0] w, input logic [3:0] isk, input logic err);
    @(posedge clk);
    #1;
    RX_DATA     = w;
    RX_ISK      = isk;
    RX_CODE_ERR = err;
  endtask

  task automatic send_frame(input logic [55:0] fd, input logic [7:0] sep, input logic hi_err,
                            input logic lo_err, input logic push, input logic seq);
    send_word(fd[55:24], ISK_HI, hi_err);
    send_word({fd[23:0], sep}, ISK_LO, lo_err);
    if (push) exp_q.push_back({cyc + 32'd2, seq, (sep == K_FC), fd});
  endtask

  task automatic good(input logic [55:0] fd, input logic push);
    send_frame(fd, seps[si], 1'b0, 1'b0, push, 1'b0);
    si = (si + 1) % 4;
  endtask

  task automatic bad_hi();
    send_frame(rnd56(), seps[si], 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // bad frame whose error lands in the same cycle as CLR_CNT; next frame is good
  task automatic clr_with_bad();
    logic [55:0] fd;
    bad_hi();
    fd = rnd56();
    send_word(fd[55:24], ISK_HI, 1'b0);
    CLR_CNT = 1'b1;
    send_word({fd[23:0], seps[si]}, ISK_LO, 1'b0);
    CLR_CNT = 1'b0;
    exp_q.push_back({cyc + 32'd2, 1'b0, 1'b0, fd});
    si = (si + 1) % 4;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, {GEM_DATA, GEM_OVERFLOW, DATA_VALID, LOCKED, LINK_RST, SEQ_ERR, SEQ_ERR_CNT, FRM_ERR_CNT}, '0);
    chk({tag, "_state"}, DBG_STATE, ST_HUNT);
  endtask

  initial begin
    seps     = '{K_BC, K_F7, K_FB, K_FD};
    seq_seps = '{K_BC, K_F7, K_FD, K_BC, K_F7, K_FB, K_FD, K_FC, K_F7, K_FC, K_FD, K_BC};
    RX_DATA = '0; RX_ISK = 4'hF; RX_CODE_ERR = 1'b0; CLR_CNT = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // stream joins mid-frame, then clean constant-payload frames
    send_word({24'h0, K_FD}, ISK_LO, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      good(56'h0123456789ABCD, i >= 9);
      if (i == 8) begin
        chk("sync_before_lock", DBG_STATE, ST_SYNC);
        chk("not_locked_after_7", LOCKED, 1'b0);
      end
      if (i == 9) chk("locked_after_8", LOCKED, 1'b1);
    end

    // separator sequence with one slip and overflow wildcards
    for (int i = 0; i < 12; i++)
      send_frame(rnd56(), seq_seps[i], 1'b0, 1'b0, 1'b1, i == 2);
    si = 1;
    chk("seq_err_cnt_one", SEQ_ERR_CNT, 4'd1);
    chk("frm_err_cnt_zero", FRM_ERR_CNT, 4'd0);

    // three code-error frames then good: stays locked
    repeat (3) bad_hi();
    good(rnd56(), 1'b1);
    good(rnd56(), 1'b1);
    chk("frm_err_cnt_three", FRM_ERR_CNT, 4'd3);
    chk("still_locked", LOCKED, 1'b1);

    // four consecutive bad frames drop the lock
    repeat (4) send_frame(rnd56(), seps[si], 1'b0, 1'b1, 1'b0, 1'b0);
    good(rnd56(), 1'b0);
    chk("unlocked_after_4", LOCKED, 1'b0);
    chk("hunt_after_4", DBG_STATE, ST_HUNT);
    chk("frm_err_cnt_seven", FRM_ERR_CNT, 4'd7);

    // relock, then push the error counter past all-ones
    repeat (7) good(rnd56(), 1'b0);
    repeat (3) begin
      repeat (3) bad_hi();
      good(rnd56(), 1'b1);
    end
    good(rnd56(), 1'b1);
    chk("relocked", LOCKED, 1'b1);
    chk("frm_err_saturated", FRM_ERR_CNT, 4'hF);

    clr_with_bad();
    clr_with_bad();
    good(rnd56(), 1'b1);
    chk("frm_err_cleared", FRM_ERR_CNT, 4'd0);
    chk("seq_err_cleared", SEQ_ERR_CNT, 4'd0);
    chk("locked_after_clear", LOCKED, 1'b1);

    // reset in the middle of a frame
    d = rnd56();
    send_word(d[55:24], ISK_HI, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained_before_reset", exp_q.size(), 0);
    rst_n = 1'b0;
    RX_ISK = 4'hF;
    #1;
    check_reset_outputs("midframe_reset");

    // link-reset idle pattern, then restart on the first hi word
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) send_word(IDLE_WORD, ISK_IDLE, 1'b0);
    chk("link_rst_during_idle", LINK_RST, 1'b1);
    chk("idle_state", DBG_STATE, ST_IDLE_RX);
    chk("idle_not_valid", DATA_VALID, 1'b0);
    si = 0;
    for (int i = 1; i <= 10; i++) begin
      good(rnd56(), i >= 9);
      if (i == 2) begin
        chk("sync_after_idle", DBG_STATE, ST_SYNC);
        chk("link_rst_released", LINK_RST, 1'b0);
      end
      if (i == 8) chk("not_locked_after_idle_7", LOCKED, 1'b0);
      if (i == 9) chk("locked_after_idle_8", LOCKED, 1'b1);
    end
    repeat (4) send_word(IDLE_WORD, ISK_IDLE, 1'b0);
    #1;
    chk("queue_empty_end", exp_q.size(), 0);
    chk("seq_err_cnt_end", SEQ_ERR_CNT, 4'd0);
    chk("frm_err_cnt_end", FRM_ERR_CNT, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
